axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning data width of all ports; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  single clock for the whole block.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports s0_awaddr/s0_awvalid, s0_awready  in/out  ADDR_WIDTH+1, 1  instruction-side write address channel.
REQ-006 SHALL have ports s0_wdata/s0_wstrb/s0_wvalid, s0_wready  in/out  DATA_WIDTH+DATA_WIDTH/8+1, 1  instruction-side write data channel.
REQ-007 SHALL have ports s0_bresp/s0_bvalid, s0_bready  out/in  2+1, 1  instruction-side write response channel.
REQ-008 SHALL have ports s0_araddr/s0_arvalid, s0_arready  in/out  ADDR_WIDTH+1, 1  instruction-side read address channel.
REQ-009 SHALL have ports s0_rdata/s0_rresp/s0_rvalid, s0_rready  out/in  DATA_WIDTH+2+1, 1  instruction-side read data channel.
REQ-010 SHALL have s1_* ports identical to REQ-005..REQ-009, for the data-cache side.
REQ-011 SHALL have m_* ports mirroring REQ-005..REQ-009 with all directions reversed, as the single downstream AXI-lite master.

Function
REQ-012 SHALL carry exactly one transaction at a time; the FSM states are IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
REQ-013 SHALL treat a port as requesting when its arvalid or awvalid is high; a port with both high is served read first.
REQ-014 SHALL arbitrate in IDLE only; with both ports requesting, the winner is the port not granted last (round-robin); the last-grant register resets to s1, so s0 wins the first tie.
REQ-015 SHALL register the winner and the read/write choice on the IDLE exit edge; the grant is held until the response handshake completes.
REQ-016 SHALL route the granted port's channels to m_* combinationally; all ready/valid signals to the non-granted port are 0.
REQ-017 SHALL move RD_ADDR->RD_DATA on m_arvalid&m_arready, and RD_DATA->IDLE on m_rvalid&m_rready.
REQ-018 SHALL issue AW and W independently in WR_ADDR/WR_DATA and track each handshake separately; it moves to WR_RESP only after both complete, in either order or in the same cycle.
REQ-019 SHALL move WR_RESP->IDLE on m_bvalid&m_bready.
REQ-020 SHALL add zero latency to any channel: one cycle from IDLE to the m_*valid assertion, and no further cycles.
REQ-021 SHALL forward rresp/bresp unmodified, including SLVERR and DECERR.
REQ-022 SHALL not re-arbitrate when the non-granted port drops its valid mid-wait; that port is simply re-evaluated on the next IDLE.
REQ-023 SHALL allow back-to-back transactions: IDLE is occupied for exactly one cycle between transactions.

Reset
REQ-024 SHALL, on rstn low at any time (including mid-transaction), go to IDLE, set last-grant to s1, clear the AW/W-done flags, and drive every output valid/ready to 0 with data outputs at 0.
REQ-025 SHALL not complete or replay an interrupted transaction after reset is released.

Configuration
REQ-026 SHALL, when ARB_FIXED_PRIO_EN is defined, replace round-robin with fixed priority in which s1 always wins a tie; the last-grant register is then absent.
REQ-027 SHALL, when ARB_FIXED_PRIO_EN is undefined, use the round-robin scheme of REQ-014.

Verification
REQ-028 SHALL cover: both arvalid rise together after reset with s0 araddr 0x1000 and s1 araddr 0x8000 -> m_araddr is 0x1000 first, then 0x8000; with ARB_FIXED_PRIO_EN the order is 0x8000 then 0x1000.
REQ-029 SHALL cover: s1 write to 0x80000010 with wstrb 0x00FF, where m_wready comes 3 cycles before m_awready -> a single m transaction and s1_bvalid with bresp 0.
REQ-030 SHALL cover: s0 asserts arvalid and awvalid together -> the read completes first, then the write, with one IDLE cycle between them.
REQ-031 SHALL cover: m_rresp=2 on an s0 read -> s0_rresp=2, and s1 sees no valid.
REQ-032 SHALL cover: rstn pulsed low in RD_DATA -> all valids are 0 in the same cycle, the FSM is in IDLE, and the next arbitration tie goes to s0.
REQ-033 SHALL cover: 100 random back-to-back requests on both ports -> no grant is starved longer than one transaction (round-robin), and each response goes only to its requester.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-port AXI-lite arbiter onto one downstream master
//
// Purpose: shares a single AXI-lite master port (m_*) between an instruction
// side (s0_*) and a data-cache side (s1_*). One transaction is in flight at a
// time; the winner's channels are routed combinationally, so the arbiter adds
// no cycles beyond the single IDLE arbitration cycle.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   s0_* / s1_*        upstream AXI-lite slave ports (AW, W, B, AR, R)
//   m_*                downstream AXI-lite master port (AW, W, B, AR, R)
//
// Configuration macro: ARB_FIXED_PRIO_EN
//   undefined - round-robin tie break (last-grant register, resets to s1)
//   defined   - fixed priority, s1 wins every tie, no last-grant register
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rstn,
  // s0: instruction side
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  output logic [1:0]              s0_bresp,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  // s1: data-cache side
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  // m: downstream master
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,  // AW outstanding; W may already be done
    WR_DATA = 3'd4,  // AW done, W still outstanding
    WR_RESP = 3'd5
  } state_e;

  state_e state_q;
  logic   gnt_q;      // 0 = s0, 1 = s1
  logic   aw_done_q;
  logic   w_done_q;
`ifndef ARB_FIXED_PRIO_EN
  logic   last_q;     // port granted most recently
`endif

  // Granted-port views of the upstream request channels
  logic [ADDR_WIDTH-1:0] sel_awaddr, sel_araddr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;

  assign sel_awaddr  = gnt_q ? s1_awaddr  : s0_awaddr;
  assign sel_awvalid = gnt_q ? s1_awvalid : s0_awvalid;
  assign sel_wdata   = gnt_q ? s1_wdata   : s0_wdata;
  assign sel_wstrb   = gnt_q ? s1_wstrb   : s0_wstrb;
  assign sel_wvalid  = gnt_q ? s1_wvalid  : s0_wvalid;
  assign sel_bready  = gnt_q ? s1_bready  : s0_bready;
  assign sel_araddr  = gnt_q ? s1_araddr  : s0_araddr;
  assign sel_arvalid = gnt_q ? s1_arvalid : s0_arvalid;
  assign sel_rready  = gnt_q ? s1_rready  : s0_rready;

  // Channel-open flags; everything is gated by these, so IDLE (and reset)
  // forces every valid/ready and data output to zero.
  logic ph_ar, ph_r, ph_aw, ph_w, ph_b;
  assign ph_ar = (state_q == RD_ADDR);
  assign ph_r  = (state_q == RD_DATA);
  assign ph_aw = (state_q == WR_ADDR) && !aw_done_q;
  assign ph_w  = ((state_q == WR_ADDR) || (state_q == WR_DATA)) && !w_done_q;
  assign ph_b  = (state_q == WR_RESP);

  assign m_arvalid = ph_ar && sel_arvalid;
  assign m_araddr  = ph_ar ? sel_araddr : '0;
  assign m_awvalid = ph_aw && sel_awvalid;
  assign m_awaddr  = ph_aw ? sel_awaddr : '0;
  assign m_wvalid  = ph_w && sel_wvalid;
  assign m_wdata   = ph_w ? sel_wdata : '0;
  assign m_wstrb   = ph_w ? sel_wstrb : '0;
  assign m_rready  = ph_r && sel_rready;
  assign m_bready  = ph_b && sel_bready;

  assign s0_arready = ph_ar && !gnt_q && m_arready;
  assign s0_awready = ph_aw && !gnt_q && m_awready;
  assign s0_wready  = ph_w  && !gnt_q && m_wready;
  assign s0_rvalid  = ph_r  && !gnt_q && m_rvalid;
  assign s0_rdata   = (ph_r && !gnt_q) ? m_rdata : '0;
  assign s0_rresp   = (ph_r && !gnt_q) ? m_rresp : 2'b00;
  assign s0_bvalid  = ph_b  && !gnt_q && m_bvalid;
  assign s0_bresp   = (ph_b && !gnt_q) ? m_bresp : 2'b00;

  assign s1_arready = ph_ar && gnt_q && m_arready;
  assign s1_awready = ph_aw && gnt_q && m_awready;
  assign s1_wready  = ph_w  && gnt_q && m_wready;
  assign s1_rvalid  = ph_r  && gnt_q && m_rvalid;
  assign s1_rdata   = (ph_r && gnt_q) ? m_rdata : '0;
  assign s1_rresp   = (ph_r && gnt_q) ? m_rresp : 2'b00;
  assign s1_bvalid  = ph_b  && gnt_q && m_bvalid;
  assign s1_bresp   = (ph_b && gnt_q) ? m_bresp : 2'b00;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid  && m_rready;
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid  && m_wready;
  assign b_hs  = m_bvalid  && m_bready;

  // Arbitration: only meaningful in IDLE
  logic req0, req1, tie_s1, pick_s1, pick_rd;
  assign req0 = s0_arvalid || s0_awvalid;
  assign req1 = s1_arvalid || s1_awvalid;
`ifdef ARB_FIXED_PRIO_EN
  assign tie_s1 = 1'b1;
`else
  assign tie_s1 = !last_q;
`endif
  assign pick_s1 = req1 && (!req0 || tie_s1);
  // A port raising both arvalid and awvalid is served read first
  assign pick_rd = pick_s1 ? s1_arvalid : s0_arvalid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt_q   <= pick_s1;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= pick_s1;
`endif
            state_q <= pick_rd ? RD_ADDR : WR_ADDR;
          end
        end
        RD_ADDR: if (ar_hs) state_q <= RD_DATA;
        RD_DATA: if (r_hs)  state_q <= IDLE;
        WR_ADDR: begin
          if (aw_hs && (w_hs || w_done_q)) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else if (aw_hs) begin
            state_q   <= WR_DATA;
            aw_done_q <= 1'b1;
          end else if (w_hs) begin
            w_done_q  <= 1'b1;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        WR_RESP: if (b_hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed and random checks for axi_lite_arbiter
module tb_axi_lite_arbiter;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int SW = DW / 8;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] s_awaddr, s_araddr;
  logic [1:0][DW-1:0] s_wdata;
  logic [1:0][SW-1:0] s_wstrb;
  logic [1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

  logic s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
  logic s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
  logic [1:0] s0_bresp, s0_rresp, s1_bresp, s1_rresp;
  logic [DW-1:0] s0_rdata, s1_rdata;

  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0] m_bresp, m_rresp;

  logic [1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0][1:0] s_bresp, s_rresp;
  logic [1:0][DW-1:0] s_rdata;
  assign s_awready = {s1_awready, s0_awready};
  assign s_wready  = {s1_wready, s0_wready};
  assign s_bvalid  = {s1_bvalid, s0_bvalid};
  assign s_arready = {s1_arready, s0_arready};
  assign s_rvalid  = {s1_rvalid, s0_rvalid};
  assign s_bresp   = {s1_bresp, s0_bresp};
  assign s_rresp   = {s1_rresp, s0_rresp};
  assign s_rdata   = {s1_rdata, s0_rdata};

  logic [14:0] all_hs;
  logic        data_or;
  assign all_hs  = {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                    s_arready, s_awready, s_wready, s_rvalid, s_bvalid};
  assign data_or = |{m_araddr, m_awaddr, m_wdata, m_wstrb, s0_rdata, s1_rdata,
                     s0_rresp, s1_rresp, s0_bresp, s1_bresp};

  int passed = 0;
  int total  = 0;

  axi_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s0_awready),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s_bready[0]),
    .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s_rready[0]),
    .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s1_awready),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s_bready[1]),
    .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s_rready[1]),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    s_bready = 2'b11; s_rready = 2'b11;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = '0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
  endtask

  task automatic issue(input int p, input logic rd, input logic [AW-1:0] a);
    s_arvalid[p] = rd;
    s_awvalid[p] = !rd;
    s_wvalid[p]  = !rd;
    s_araddr[p]  = a;
    s_awaddr[p]  = a;
    s_wdata[p]   = {$urandom(), $urandom(), $urandom(), $urandom()};
    s_wstrb[p]   = 16'($urandom());
  endtask

  // Downstream read slave: entered in RD_ADDR, returns in the following IDLE cycle
  task automatic run_read(input int p, input int dar, input logic [DW-1:0] d, input logic [1:0] r,
                          output logic [1:0] arr, output logic [1:0] rv,
                          output logic [DW-1:0] rd, output logic [1:0] rr, output logic to);
    logic hs;
    arr = '0;
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      m_arready = (c >= dar);
      #1;
      hs = m_arvalid && m_arready;
      if (hs) arr = s_arready;
      tick();
      if (hs) begin
        s_arvalid[p] = 1'b0;
        to = 1'b0;
        break;
      end
    end
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = d; m_rresp = r;
    #1;
    rv = s_rvalid; rd = s_rdata[p]; rr = s_rresp[p];
    tick();
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
  endtask

  // Downstream write slave: AW/W readiness delayed independently from WR_ADDR entry
  task automatic run_write(input int p, input int daw, input int dw, input logic [1:0] resp,
                           output int awc, output int wc, output logic [1:0] bv,
                           output logic [1:0] br, output logic to);
    logic hs_aw, hs_w, aw_ok, w_ok;
    awc = 0; wc = 0; aw_ok = 1'b0; w_ok = 1'b0;
    for (int c = 0; c < 20 && !(aw_ok && w_ok); c++) begin
      m_awready = (c >= daw);
      m_wready  = (c >= dw);
      #1;
      hs_aw = m_awvalid && m_awready;
      hs_w  = m_wvalid && m_wready;
      tick();
      if (hs_aw) begin awc++; aw_ok = 1'b1; s_awvalid[p] = 1'b0; end
      if (hs_w)  begin wc++;  w_ok  = 1'b1; s_wvalid[p]  = 1'b0; end
    end
    to = !(aw_ok && w_ok);
    m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = resp;
    #1;
    bv = s_bvalid; br = s_bresp[p];
    tick();
    m_bvalid = 1'b0; m_bresp = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    s_arvalid = 2'b11; s_awvalid = 2'b11; s_wvalid = 2'b11;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_rvalid = 1'b1; m_bvalid = 1'b1; m_rdata = '1; m_rresp = 2'b11; m_bresp = 2'b11;
    tick();
    total++;
    if (all_hs !== 15'd0) $display("FAIL reset_handshakes got %h want 0", all_hs);
    else passed++;
    total++;
    if (data_or !== 1'b0) $display("FAIL reset_data got %b want 0", data_or);
    else passed++;
    clear_inputs();
    rstn = 1'b1;
    tick(); tick();
    total++;
    if (all_hs !== 15'd0) $display("FAIL post_reset_idle got %h want 0", all_hs);
    else passed++;
  endtask

  task automatic test_tie();
    logic [1:0] arr, rv, rr, oh;
    logic [DW-1:0] rd;
    logic [AW-1:0] exp_a;
    logic to;
    int first;
    first = FIXED ? 1 : 0;
    clear_inputs();
    s_araddr[0] = 64'h1000; s_araddr[1] = 64'h8000; s_arvalid = 2'b11;
    tick();
    exp_a = first ? 64'h8000 : 64'h1000;
    total++;
    if (m_arvalid !== 1'b1 || m_araddr !== exp_a)
      $display("FAIL tie_first_addr got v=%b a=%h want v=1 a=%h", m_arvalid, m_araddr, exp_a);
    else passed++;
    oh = first ? 2'b10 : 2'b01;
    run_read(first, 1, 128'hA5A5, 2'b00, arr, rv, rd, rr, to);
    total++;
    if (to || arr !== oh || rv !== oh)
      $display("FAIL tie_first_route got arr=%b rv=%b to=%b want %b", arr, rv, to, oh);
    else passed++;
    total++;
    if (rd !== 128'hA5A5) $display("FAIL tie_first_rdata got %h want a5a5", rd);
    else passed++;
    total++;
    if (m_arvalid !== 1'b0) $display("FAIL tie_idle_gap got %b want 0", m_arvalid);
    else passed++;
    tick();
    exp_a = first ? 64'h1000 : 64'h8000;
    total++;
    if (m_arvalid !== 1'b1 || m_araddr !== exp_a)
      $display("FAIL tie_second_addr got v=%b a=%h want v=1 a=%h", m_arvalid, m_araddr, exp_a);
    else passed++;
    run_read(1 - first, 0, 128'h5A5A, 2'b00, arr, rv, rd, rr, to);
    total++;
    if (to || rv !== ~oh || rd !== 128'h5A5A)
      $display("FAIL tie_second_resp got rv=%b rd=%h want rv=%b rd=5a5a", rv, rd, ~oh);
    else passed++;
  endtask

  task automatic test_write_s1();
    logic [1:0] bv, br;
    logic to;
    int awc, wc;
    clear_inputs();
    s_awaddr[1] = 64'h8000_0010;
    s_wdata[1]  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    s_wstrb[1]  = 16'h00FF;
    s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
    tick();
    total++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== 64'h8000_0010)
      $display("FAIL wr_issue got awv=%b wv=%b a=%h want 1 1 80000010", m_awvalid, m_wvalid, m_awaddr);
    else passed++;
    total++;
    if (m_wstrb !== 16'h00FF || m_wdata !== 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210)
      $display("FAIL wr_data got strb=%h data=%h", m_wstrb, m_wdata);
    else passed++;
    run_write(1, 3, 0, 2'b00, awc, wc, bv, br, to);
    total++;
    if (to || awc != 1 || wc != 1)
      $display("FAIL wr_single got aw=%0d w=%0d to=%b want 1 1 0", awc, wc, to);
    else passed++;
    total++;
    if (bv !== 2'b10 || br !== 2'b00) $display("FAIL wr_bresp got bv=%b br=%b want 10 00", bv, br);
    else passed++;
  endtask

  task automatic test_rd_then_wr();
    logic [1:0] arr, rv, rr, bv, br;
    logic [DW-1:0] rd;
    logic to;
    int awc, wc;
    clear_inputs();
    s_araddr[0] = 64'h40; s_awaddr[0] = 64'h80; s_wdata[0] = 128'h77; s_wstrb[0] = '1;
    s_arvalid[0] = 1'b1; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
    tick();
    total++;
    if ({m_arvalid, m_awvalid} !== 2'b10) $display("FAIL rw_read_first got %b want 10", {m_arvalid, m_awvalid});
    else passed++;
    run_read(0, 0, 128'h1234, 2'b00, arr, rv, rd, rr, to);
    total++;
    if (to || rv !== 2'b01 || rd !== 128'h1234) $display("FAIL rw_read_resp got rv=%b rd=%h want 01 1234", rv, rd);
    else passed++;
    total++;
    if ({m_arvalid, m_awvalid, m_wvalid} !== 3'b000)
      $display("FAIL rw_idle_gap got %b want 000", {m_arvalid, m_awvalid, m_wvalid});
    else passed++;
    tick();
    total++;
    if ({m_awvalid, m_wvalid} !== 2'b11 || m_awaddr !== 64'h80)
      $display("FAIL rw_write_next got %b a=%h want 11 80", {m_awvalid, m_wvalid}, m_awaddr);
    else passed++;
    run_write(0, 0, 0, 2'b00, awc, wc, bv, br, to);
    total++;
    if (to || awc != 1 || wc != 1 || bv !== 2'b01)
      $display("FAIL rw_write_resp got aw=%0d w=%0d bv=%b want 1 1 01", awc, wc, bv);
    else passed++;
  endtask

  task automatic test_errors();
    logic [1:0] arr, rv, rr, bv, br;
    logic [DW-1:0] rd;
    logic to;
    int awc, wc;
    clear_inputs();
    s_araddr[0] = 64'h300; s_arvalid[0] = 1'b1;
    tick();
    run_read(0, 0, 128'hDEAD, 2'd2, arr, rv, rd, rr, to);
    total++;
    if (to || rv !== 2'b01) $display("FAIL slverr_route got rv=%b want 01", rv);
    else passed++;
    total++;
    if (rr !== 2'd2) $display("FAIL slverr_rresp got %0d want 2", rr);
    else passed++;
    issue(0, 1'b0, 64'h500);
    tick();
    run_write(0, 1, 2, 2'd3, awc, wc, bv, br, to);
    total++;
    if (to || bv !== 2'b01 || br !== 2'd3) $display("FAIL decerr_bresp got bv=%b br=%0d want 01 3", bv, br);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] arr, rv, rr;
    logic [DW-1:0] rd;
    logic [AW-1:0] exp_a;
    logic to;
    int first;
    clear_inputs();
    s_araddr[0] = 64'h2000; s_arvalid[0] = 1'b1;
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0; s_arvalid[0] = 1'b0;
    m_rvalid = 1'b1; m_rdata = '1;
    #1;
    total++;
    if (s_rvalid !== 2'b01) $display("FAIL rstmid_in_rdata got %b want 01", s_rvalid);
    else passed++;
    rstn = 1'b0;
    #1;
    total++;
    if (all_hs !== 15'd0 || data_or !== 1'b0)
      $display("FAIL rstmid_outputs got hs=%h data=%b want 0 0", all_hs, data_or);
    else passed++;
    total++;
    if (3'(dut.state_q) !== 3'd0) $display("FAIL rstmid_state got %0d want 0", 3'(dut.state_q));
    else passed++;
    m_rvalid = 1'b0; m_rdata = '0;
    tick();
    rstn = 1'b1;
    tick(); tick();
    total++;
    if (all_hs !== 15'd0) $display("FAIL rstmid_no_replay got %h want 0", all_hs);
    else passed++;
    s_araddr[0] = 64'h1000; s_araddr[1] = 64'h8000; s_arvalid = 2'b11;
    tick();
    first = FIXED ? 1 : 0;
    exp_a = first ? 64'h8000 : 64'h1000;
    total++;
    if (m_araddr !== exp_a) $display("FAIL rstmid_tie got %h want %h", m_araddr, exp_a);
    else passed++;
    run_read(first, 0, 128'h1, 2'b00, arr, rv, rd, rr, to);
    // loser withdraws before the next IDLE edge: nothing must be granted
    s_arvalid = 2'b00;
    tick();
    total++;
    if (all_hs !== 15'd0) $display("FAIL rstmid_withdraw got %h want 0", all_hs);
    else passed++;
  endtask

  task automatic test_random();
    logic [1:0] arr, rv, rr, bv, br, r, oh;
    logic [DW-1:0] d, rdv;
    logic to, rd;
    int awc, wc, owner, exp_owner;
    clear_inputs();
    issue(0, 1'($urandom_range(0, 1)), 64'h0);
    issue(1, 1'($urandom_range(0, 1)), 64'h1000_0000_0000_0000);
    // the previous scenario's last grant was s0 (round-robin) so s1 is next either way
    exp_owner = 1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (m_arvalid) begin owner = int'(m_araddr[60]); rd = 1'b1; end
      else if (m_awvalid) begin owner = int'(m_awaddr[60]); rd = 1'b0; end
      else begin owner = -1; rd = 1'b0; end
      total++;
      if (owner != exp_owner) begin
        $display("FAIL rnd_grant n=%0d got %0d want %0d", n, owner, exp_owner);
        break;
      end else passed++;
      oh = (owner == 1) ? 2'b10 : 2'b01;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      r = 2'($urandom_range(0, 3));
      if (rd) begin
        run_read(owner, $urandom_range(0, 2), d, r, arr, rv, rdv, rr, to);
        total++;
        if (to || arr !== oh || rv !== oh || rdv !== d || rr !== r)
          $display("FAIL rnd_read n=%0d got arr=%b rv=%b rr=%0d to=%b want %b %b %0d", n, arr, rv, rr, to, oh, oh, r);
        else passed++;
      end else begin
        run_write(owner, $urandom_range(0, 3), $urandom_range(0, 3), r, awc, wc, bv, br, to);
        total++;
        if (to || awc != 1 || wc != 1 || bv !== oh || br !== r)
          $display("FAIL rnd_write n=%0d got aw=%0d w=%0d bv=%b br=%0d want 1 1 %b %0d", n, awc, wc, bv, br, oh, r);
        else passed++;
      end
      issue(owner, 1'($urandom_range(0, 1)), (64'(owner) << 60) | 64'(n + 1));
      exp_owner = FIXED ? 1 : 1 - owner;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_tie();
    test_write_s1();
    test_rd_then_wr();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
